// File: rtl/branch_resolve_pipe_if.sv
// Handshake and data bundle for branch_resolve_pipe.
// master: producer of branch operations and consumer of resolved results.
// slave : the branch resolution unit itself.
//   in_valid/in_ready        operation handshake
//   op, op_a, op_b, offset   decoded operation and operands
//   pc                       address of the branch/jump instruction
//   flush                    kill every in-flight operation
//   out_valid/out_ready      result handshake
//   target, link, taken, we  resolved redirect, return address and flags
//   misalign                 taken with a misaligned target
//   taken_cnt                saturating count of retired taken operations
interface branch_resolve_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [XLEN-1:0]  offset;
  logic [XLEN-1:0]  pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  link;
  logic             taken;
  logic             we;
  logic             misalign;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output in_valid, op, op_a, op_b, offset, pc, flush, out_ready,
    input  in_ready, out_valid, target, link, taken, we, misalign, taken_cnt
  );

  modport slave (
    input  in_valid, op, op_a, op_b, offset, pc, flush, out_ready,
    output in_ready, out_valid, target, link, taken, we, misalign, taken_cnt
  );
endinterface

// File: rtl/branch_resolve_pipe.sv
// Branch/jump resolution unit with an elastic DEPTH-stage pipeline.
// The result is computed combinationally from the inputs and captured in
// stage 0; the remaining stages only carry it forward. Outputs come straight
// from the last stage registers; in_ready is the only combinational output.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      branch_resolve_pipe_if.slave (handshakes, operands, results)
module branch_resolve_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 3,
  parameter int C_EXT = 0,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  branch_resolve_pipe_if.slave  bus
);

  localparam logic [3:0] OP_BEQ  = 4'd0;
  localparam logic [3:0] OP_BNE  = 4'd1;
  localparam logic [3:0] OP_BLT  = 4'd2;
  localparam logic [3:0] OP_BLTU = 4'd3;
  localparam logic [3:0] OP_BGE  = 4'd4;
  localparam logic [3:0] OP_BGEU = 4'd5;
  localparam logic [3:0] OP_JAL  = 4'd6;
  localparam logic [3:0] OP_JALR = 4'd7;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] adv;
  logic [XLEN-1:0]  target_q [DEPTH];
  logic [XLEN-1:0]  target_d [DEPTH];
  logic [XLEN-1:0]  link_q   [DEPTH];
  logic [XLEN-1:0]  link_d   [DEPTH];
  logic [DEPTH-1:0] taken_q, taken_d;
  logic [DEPTH-1:0] we_q, we_d;
  logic [DEPTH-1:0] mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0]  sum_ab;
  logic [XLEN-1:0]  br_tgt;
  logic [XLEN-1:0]  res_tgt;
  logic [XLEN-1:0]  res_link;
  logic             res_taken;
  logic             res_jump;
  logic             res_mis;
  logic             down_free;
  logic             accept;

  always_comb begin
    sum_ab    = bus.op_a + bus.op_b;
    br_tgt    = bus.pc + bus.offset;
    res_tgt   = br_tgt;
    res_taken = 1'b0;
    res_jump  = 1'b0;
    case (bus.op)
      OP_BEQ:  res_taken = (bus.op_a == bus.op_b);
      OP_BNE:  res_taken = (bus.op_a != bus.op_b);
      OP_BLT:  res_taken = ($signed(bus.op_a) <  $signed(bus.op_b));
      OP_BLTU: res_taken = (bus.op_a <  bus.op_b);
      OP_BGE:  res_taken = ($signed(bus.op_a) >= $signed(bus.op_b));
      OP_BGEU: res_taken = (bus.op_a >= bus.op_b);
      OP_JAL: begin
        res_taken = 1'b1;
        res_jump  = 1'b1;
        res_tgt   = sum_ab;
      end
      OP_JALR: begin
        res_taken = 1'b1;
        res_jump  = 1'b1;
        res_tgt   = {sum_ab[XLEN-1:1], 1'b0};
      end
      default: res_taken = 1'b0;
    endcase
    // bit 1 only matters without compressed instructions; bit 0 always does
    res_mis  = res_taken && (res_tgt[0] || ((C_EXT == 0) && res_tgt[1]));
    res_link = res_jump ? (bus.pc + XLEN'(32'd4)) : '0;
  end

  // Walk from the output back to stage 0: a stage advances when it holds
  // data and everything downstream of it can take a new entry this cycle.
  always_comb begin
    down_free = bus.out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k]    = valid_q[k] && down_free;
      down_free = !valid_q[k] || adv[k];
    end
  end

  assign bus.in_ready = !reset_n || down_free;
  assign accept       = bus.in_valid && down_free;

  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    link_d   = link_q;
    taken_d  = taken_q;
    we_d     = we_q;
    mis_d    = mis_q;
    cnt_d    = cnt_q;
    if (bus.flush) begin
      // the entry sitting at the output is killed too, so it never counts
      valid_d = '0;
    end else begin
      if (adv[DEPTH-1] && taken_q[DEPTH-1] && !mis_q[DEPTH-1] && (cnt_q != '1))
        cnt_d = cnt_q + CNT_W'(1);
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (adv[k-1]) begin
          valid_d[k]  = 1'b1;
          target_d[k] = target_q[k-1];
          link_d[k]   = link_q[k-1];
          taken_d[k]  = taken_q[k-1];
          we_d[k]     = we_q[k-1];
          mis_d[k]    = mis_q[k-1];
        end else if (adv[k]) begin
          valid_d[k] = 1'b0;
        end
      end
      if (accept) begin
        valid_d[0]  = 1'b1;
        target_d[0] = res_tgt;
        link_d[0]   = res_link;
        taken_d[0]  = res_taken;
        we_d[0]     = res_jump && !res_mis;
        mis_d[0]    = res_mis;
      end else if (adv[0]) begin
        valid_d[0] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      taken_q <= '0;
      we_q    <= '0;
      mis_q   <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        target_q[k] <= '0;
        link_q[k]   <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
      link_q   <= link_d;
      taken_q  <= taken_d;
      we_q     <= we_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.target    = target_q[DEPTH-1];
  assign bus.link      = link_q[DEPTH-1];
  assign bus.taken     = taken_q[DEPTH-1];
  assign bus.we        = we_q[DEPTH-1];
  assign bus.misalign  = mis_q[DEPTH-1];
  assign bus.taken_cnt = cnt_q;

endmodule
